mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 49 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port bus arbiter between instruction fetch and data access.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] SEL_WORD = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_ACC   = 3'd1,
        ST_MEM_ACC  = 3'd2,
        ST_IF_DONE  = 3'd3,
        ST_MEM_DONE = 3'd4,
        ST_DRAIN    = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // A fetch is always a full-word read; the write data lane is left as it was.
    function automatic bus_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] prev_wdata);
        bus_cmd_t c;
        c.we    = 1'b0;
        c.sel   = SEL_WORD;
        c.addr  = addr;
        c.wdata = prev_wdata;
        return c;
    endfunction

    function automatic bus_cmd_t data_cmd(input logic              we,
                                          input logic [SEL_W-1:0]  sel,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] wdata);
        bus_cmd_t c;
        c.we    = we;
        c.sel   = sel;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one registered bus; data wins,
// a flushed fetch is drained, and a data access always runs to completion.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_inst_o,

    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,

    output logic              if_stallreq_o,
    output logic              mem_stallreq_o,
    input  logic              flush_i,

    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i
);

    arb_state_e        state_q, state_d;
    bus_cmd_t          cmd_q, cmd_d;
    logic              bus_req_q, bus_req_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            bus_req_q   <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bus_req_q   <= bus_req_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bus_req_d   = bus_req_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!flush_i && mem_ce_i) begin
                    cmd_d     = data_cmd(mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i);
                    bus_req_d = 1'b1;
                    state_d   = ST_MEM_ACC;
                end else if (!flush_i && if_ce_i) begin
                    cmd_d     = fetch_cmd(if_addr_i, cmd_q.wdata);
                    bus_req_d = 1'b1;
                    state_d   = ST_IF_ACC;
                end
            end

            // A flush racing the ack simply drops the instruction.
            ST_IF_ACC: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        if_inst_d = bus_rdata_i;
                        state_d   = ST_IF_DONE;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_MEM_ACC: begin
                if (bus_ack_i) begin
                    bus_req_d   = 1'b0;
                    mem_rdata_d = bus_rdata_i;
                    state_d     = ST_MEM_DONE;
                end
            end

            ST_IF_DONE, ST_MEM_DONE: begin
                state_d = ST_IDLE;
            end

            ST_DRAIN: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign if_stallreq_o  = if_ce_i  && (state_q != ST_IF_DONE);
    assign mem_stallreq_o = mem_ce_i && (state_q != ST_MEM_DONE);

    assign if_inst_o   = if_inst_q;
    assign mem_rdata_o = mem_rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = cmd_q.we;
    assign bus_sel_o   = cmd_q.sel;
    assign bus_addr_o  = cmd_q.addr;
    assign bus_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives mem_arbiter with directed scenarios then random traffic, comparing every
// cycle against a transaction-level model of who owns the bus and what must come back.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        if_stall;
    logic        mem_stall;
    logic        flush;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .if_ce_i        (if_ce),
        .if_addr_i      (if_addr),
        .if_inst_o      (if_inst),
        .mem_ce_i       (mem_ce),
        .mem_we_i       (mem_we),
        .mem_sel_i      (mem_sel),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .mem_rdata_o    (mem_rdata),
        .if_stallreq_o  (if_stall),
        .mem_stallreq_o (mem_stall),
        .flush_i        (flush),
        .bus_req_o      (bus_req),
        .bus_we_o       (bus_we),
        .bus_sel_o      (bus_sel),
        .bus_addr_o     (bus_addr),
        .bus_wdata_o    (bus_wdata),
        .bus_rdata_i    (bus_rdata),
        .bus_ack_i      (bus_ack)
    );

    // Reference model: an outstanding transaction, its owner (1 fetch, 2 data),
    // whether a flushed fetch's data must be thrown away, and the one-cycle
    // completion window (doneSide) in which the owner's stall is released.
    logic        modelValid = 1'b0;
    logic [1:0]  owner;
    logic        dropFetch;
    logic [1:0]  doneSide;
    logic        eReq;
    logic        eWe;
    logic [3:0]  eSel;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic [31:0] eInst;
    logic [31:0] eRdata;

    always @(posedge clk) begin
        if (rst) begin
            modelValid <= 1'b1;
            owner      <= 2'd0;
            dropFetch  <= 1'b0;
            doneSide   <= 2'd0;
            eReq       <= 1'b0;
            eWe        <= 1'b0;
            eSel       <= 4'h0;
            eAddr      <= 32'h0;
            eWdata     <= 32'h0;
            eInst      <= 32'h0;
            eRdata     <= 32'h0;
        end else if (doneSide != 2'd0) begin
            doneSide <= 2'd0;
        end else if (eReq) begin
            if (owner == 2'd2) begin
                if (bus_ack) begin
                    eReq     <= 1'b0;
                    eRdata   <= bus_rdata;
                    doneSide <= 2'd2;
                end
            end else if (dropFetch) begin
                if (bus_ack) begin
                    eReq      <= 1'b0;
                    dropFetch <= 1'b0;
                end
            end else if (bus_ack) begin
                eReq <= 1'b0;
                if (!flush) begin
                    eInst    <= bus_rdata;
                    doneSide <= 2'd1;
                end
            end else if (flush) begin
                dropFetch <= 1'b1;
            end
        end else if (!flush && mem_ce) begin
            eReq   <= 1'b1;
            owner  <= 2'd2;
            eWe    <= mem_we;
            eSel   <= mem_sel;
            eAddr  <= mem_addr;
            eWdata <= mem_wdata;
        end else if (!flush && if_ce) begin
            eReq  <= 1'b1;
            owner <= 2'd1;
            eWe   <= 1'b0;
            eSel  <= 4'hF;
            eAddr <= if_addr;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("bus_req",      32'(bus_req),   32'(eReq));
            checkOutput("bus_we",       32'(bus_we),    32'(eWe));
            checkOutput("bus_sel",      32'(bus_sel),   32'(eSel));
            checkOutput("bus_addr",     bus_addr,       eAddr);
            checkOutput("bus_wdata",    bus_wdata,      eWdata);
            checkOutput("if_inst",      if_inst,        eInst);
            checkOutput("mem_rdata",    mem_rdata,      eRdata);
            checkOutput("if_stallreq",  32'(if_stall),  32'(if_ce  && (doneSide != 2'd1)));
            checkOutput("mem_stallreq", 32'(mem_stall), 32'(mem_ce && (doneSide != 2'd2)));
        end
    end

    task automatic advance();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus();
        rst       = ($urandom_range(0, 199) == 0);
        if_ce     = ($urandom_range(0, 9) < 7);
        if_addr   = $urandom;
        mem_ce    = ($urandom_range(0, 9) < 4);
        mem_we    = 1'($urandom);
        mem_sel   = 4'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        flush     = ($urandom_range(0, 15) == 0);
        bus_ack   = ($urandom_range(0, 2) == 0);
        bus_rdata = $urandom;
    endtask

    initial begin
        rst = 1'b1; if_ce = 1'b0; if_addr = '0; mem_ce = 1'b0; mem_we = 1'b0;
        mem_sel = '0; mem_addr = '0; mem_wdata = '0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        advance();
        advance();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset bus_req", 32'(bus_req), 32'd0);
        checkOutput("reset if_inst", if_inst, 32'd0);

        // Fetch only, ack one cycle after issue
        if_ce = 1'b1; if_addr = 32'h3000_0000;
        advance();
        bus_ack = 1'b1; bus_rdata = 32'h2401_0001;
        @(negedge clk);
        checkOutput("fetch issue bus_req", 32'(bus_req), 32'd1);
        checkOutput("fetch issue bus_addr", bus_addr, 32'h3000_0000);
        checkOutput("fetch issue bus_sel", 32'(bus_sel), 32'hF);
        checkOutput("fetch acc if_stall", 32'(if_stall), 32'd1);
        advance();
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("fetch done if_inst", if_inst, 32'h2401_0001);
        checkOutput("fetch done if_stall", 32'(if_stall), 32'd0);
        checkOutput("fetch done bus_req", 32'(bus_req), 32'd0);
        checkOutput("model fetch eInst", eInst, 32'h2401_0001);
        advance();

        // Contention: store first, then fetch
        if_addr = 32'h3000_0004; mem_ce = 1'b1; mem_we = 1'b1;
        mem_addr = 32'h80; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
        advance();
        bus_ack = 1'b1; bus_rdata = 32'h0;
        @(negedge clk);
        checkOutput("contend store bus_we", 32'(bus_we), 32'd1);
        checkOutput("contend store bus_addr", bus_addr, 32'h80);
        checkOutput("contend store bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        checkOutput("contend both stall", 32'({if_stall, mem_stall}), 32'd3);
        advance();
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("contend mem_stall drops", 32'(mem_stall), 32'd0);
        checkOutput("contend if_stall held", 32'(if_stall), 32'd1);
        advance();
        mem_ce = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        checkOutput("contend idle bus_req", 32'(bus_req), 32'd0);
        advance();
        bus_ack = 1'b1; bus_rdata = 32'h8C22_0000;
        @(negedge clk);
        checkOutput("contend fetch bus_addr", bus_addr, 32'h3000_0004);
        checkOutput("contend fetch bus_we", 32'(bus_we), 32'd0);
        advance();
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("contend fetch if_inst", if_inst, 32'h8C22_0000);
        advance();

        // Flush mid-fetch: drain, then fetch again
        if_addr = 32'h3000_0008;
        advance();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush fetch issued", 32'(bus_req), 32'd1);
        advance();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("drain bus_req held", 32'(bus_req), 32'd1);
        checkOutput("drain if_stall", 32'(if_stall), 32'd1);
        advance();
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("drain wait bus_req", 32'(bus_req), 32'd1);
        advance();
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("drain done if_inst kept", if_inst, 32'h8C22_0000);
        checkOutput("drain done bus_req", 32'(bus_req), 32'd0);
        checkOutput("drain done if_stall", 32'(if_stall), 32'd1);
        advance();
        bus_ack = 1'b1; bus_rdata = 32'h3C1D_8000;
        @(negedge clk);
        checkOutput("refetch bus_addr", bus_addr, 32'h3000_0008);
        advance();
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("refetch if_inst", if_inst, 32'h3C1D_8000);
        advance();

        // Flush during a load has no effect
        if_ce = 1'b0; mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_sel = 4'h3;
        advance();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("load bus_sel", 32'(bus_sel), 32'h3);
        advance();
        flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("load after flush bus_req", 32'(bus_req), 32'd1);
        advance();
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("load mem_rdata", mem_rdata, 32'hCAFE_F00D);
        checkOutput("load done mem_stall", 32'(mem_stall), 32'd0);
        checkOutput("model load eRdata", eRdata, 32'hCAFE_F00D);
        advance();

        // Reset in the middle of a store, then a stray ack
        mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h1234_5678; mem_sel = 4'hF;
        advance();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("pre-reset bus_req", 32'(bus_req), 32'd1);
        advance();
        @(negedge clk);
        checkOutput("reset bus_req", 32'(bus_req), 32'd0);
        checkOutput("reset bus_addr", bus_addr, 32'd0);
        checkOutput("reset bus_wdata", bus_wdata, 32'd0);
        checkOutput("reset bus_sel", 32'(bus_sel), 32'd0);
        checkOutput("reset mem_rdata", mem_rdata, 32'd0);
        checkOutput("reset mem_stall follows ce", 32'(mem_stall), 32'd1);
        advance();
        rst = 1'b0; mem_ce = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk);
        checkOutput("stray ack idle", 32'(bus_req), 32'd0);
        advance();
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("stray ack ignored", mem_rdata, 32'd0);

        // Wait states: qualifiers stay stable while inputs wander
        mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hA5A5_A5A5; mem_sel = 4'hC;
        advance();
        for (int i = 0; i < 6; i++) begin
            mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom);
            if (i == 5) begin
                bus_ack = 1'b1;
            end
            @(negedge clk);
            checkOutput("wait bus_addr", bus_addr, 32'h300);
            checkOutput("wait bus_sel", 32'(bus_sel), 32'hC);
            checkOutput("wait bus_wdata", bus_wdata, 32'hA5A5_A5A5);
            checkOutput("wait mem_stall", 32'(mem_stall), 32'd1);
            advance();
        end
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("wait done mem_stall", 32'(mem_stall), 32'd0);
        advance();

        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
